// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: FSM states, access-size codes,
// bus request payload and the alignment rule.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    // Same encoding as the store-width select (B/H/W); 3 is reserved.
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [BE_W-1:0]   be;
        logic [XLEN-1:0]   wdata;
    } bus_req_t;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = ~addr_lo[0];
            SIZE_W:  ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and replicated store data toward the bus,
// lane extraction plus sign/zero extension of read data back to the core.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [BE_W-1:0] be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        be_o    = '0;
        wdata_o = wdata_i;
        case (size_i)
            SIZE_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SIZE_H: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            SIZE_W:  be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_lane = rdata_i[7:0];
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            default: byte_lane = rdata_i[31:24];
        endcase
        half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Zero-extension is sign-extension with the fill bit forced low.
    always_comb begin
        case (size_i)
            SIZE_B:  rdata_o = {{24{byte_lane[7] & ~unsigned_i}}, byte_lane};
            SIZE_H:  rdata_o = {{16{half_lane[15] & ~unsigned_i}}, half_lane};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: runs one memory request over a valid/ready address phase and a
// response phase while stalling the core. Optional bus watchdog under LSU_TIMEOUT_EN.
module lsu_sequencer
    import lsu_pkg::*;
#(
`ifdef LSU_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;
`endif

    state_e          state_q, state_d;
    bus_req_t        req_q, req_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [1:0]      lo_q, lo_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] load_q, load_d;

    logic [1:0]      al_size;
    logic            al_uns;
    logic [1:0]      al_lo;
    logic [BE_W-1:0] al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;

    // Steer the incoming request while idle, the captured request otherwise.
    assign al_size = (state_q == IDLE) ? req_size     : size_q;
    assign al_uns  = (state_q == IDLE) ? req_unsigned : uns_q;
    assign al_lo   = (state_q == IDLE) ? req_addr[1:0] : lo_q;

    lsu_lane_align u_align (
        .size_i     (al_size),
        .unsigned_i (al_uns),
        .addr_lo_i  (al_lo),
        .wdata_i    (req_wdata),
        .rdata_i    (bus_rdata),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata)
    );

`ifdef LSU_TIMEOUT_EN
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            lo_q    <= '0;
            fault_q <= 1'b0;
            load_q  <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            lo_q    <= lo_d;
            fault_q <= fault_d;
            load_q  <= load_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        size_d  = size_q;
        uns_d   = uns_q;
        lo_d    = lo_q;
        fault_d = 1'b0;
        load_d  = load_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q + CNT_W'(1);
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!is_aligned(req_size, req_addr[1:0])) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d = ADDR;
                        req_d   = '{we: req_we, addr: {req_addr[31:2], 2'b00}, be: al_be, wdata: al_wdata};
                        size_d  = req_size;
                        uns_d   = req_unsigned;
                        lo_d    = req_addr[1:0];
                    end
                end
`ifdef LSU_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            ADDR: begin
                if (bus_ready) begin
                    if (req_q.we) begin
                        state_d = DONE;
                    end else if (bus_rvalid) begin
                        state_d = DONE;
                        load_d  = al_rdata;
                    end else begin
                        state_d = RESP;
                    end
`ifdef LSU_TIMEOUT_EN
                end else if (timeout) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    load_d  = '0;
`endif
                end
            end
            RESP: begin
                if (bus_rvalid) begin
                    state_d = DONE;
                    load_d  = al_rdata;
`ifdef LSU_TIMEOUT_EN
                end else if (timeout) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    load_d  = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall     = (state_q != DONE) && ((state_q != IDLE) || req_valid);
        bus_valid = (state_q == ADDR);
        done      = (state_q == DONE);
    end

    assign fault     = fault_q;
    assign load_data = load_q;
    assign bus_we    = req_q.we;
    assign bus_addr  = req_q.addr;
    assign bus_be    = req_q.be;
    assign bus_wdata = req_q.wdata;

endmodule
